pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage RISC-V pipeline. Drives the ENABLE and RESET (flush) inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC register enable. It resolves load-use hazards, squashes wrong-path instructions on taken branches, and freezes the pipeline while data memory is busy. A wait-state watchdog halts the core on a memory timeout, and saturating stall and flush counters support performance analysis.

## Interface
- RW, 5: register-address width.
- CW, 32: width of the performance counters.
- TIMEOUT, 16: maximum number of consecutive memory-wait cycles before halt (≥2).

- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- ID_RS1, ID_RS2  in  RW each  source registers of the instruction in ID.
- ID_USE_RS1, ID_USE_RS2  in  1 each  the ID instruction actually reads RS1 / RS2.
- EX_RD  in  RW  destination register of the instruction in EX.
- EX_MEMREAD  in  1  the EX instruction is a load.
- EX_BRANCH_TAKEN  in  1  the EX stage redirects the PC (taken branch or jump).
- MEM_REQ  in  1  the MEM instruction accesses data memory.
- MEM_READY  in  1  data memory completes the access this cycle.
- PC_EN, IFID_EN, IDEX_EN, EXMEM_EN, MEMWB_EN  out  1 each  register enables.
- IFID_FLUSH, IDEX_FLUSH, EXMEM_FLUSH, MEMWB_FLUSH  out  1 each  drive the register RESET pins: the register loads zero (a bubble) at the next edge, with priority over enable.
- ERR  out  1  sticky memory-timeout flag.
- STALL_CNT, FLUSH_CNT  out  CW each  saturating event counters.

## Operation
- Hazard terms are combinational and evaluated every cycle:
  - `loaduse` = EX_MEMREAD & (EX_RD≠0) & ((ID_USE_RS1 & ID_RS1==EX_RD) | (ID_USE_RS2 & ID_RS2==EX_RD)).
  - `memstall` = MEM_REQ & ~MEM_READY.
  - `redirect` = EX_BRANCH_TAKEN.
- Control-output priority is HALT > memstall > redirect > loaduse > run. Outputs are combinational from the current state and inputs.
  - **HALT:** all EN=0 and all FLUSH=0, so the pipeline is frozen.
  - **memstall:** PC_EN=IFID_EN=IDEX_EN=EXMEM_EN=0; MEMWB_EN=1 with MEMWB_FLUSH=1 (a bubble into WB prevents a repeated write-back); other FLUSH=0. A redirect or load-use during a wait is ignored. The source instructions stay frozen and are re-evaluated when the wait ends.
  - **redirect:** all EN=1; IFID_FLUSH=IDEX_FLUSH=1, squashing the two younger instructions. Redirect beats loaduse because the dependent instruction is squashed anyway.
  - **loaduse:** PC_EN=IFID_EN=0; IDEX_EN=1 with IDEX_FLUSH=1; EXMEM_EN=MEMWB_EN=1. This inserts exactly one bubble per cycle of the condition.
  - **run:** all EN=1 and all FLUSH=0.
- The FSM has states RUN, MWAIT and HALT, with a wait counter WCNT of width clog2(TIMEOUT+1).
  - RUN→MWAIT when memstall; WCNT←1.
  - MWAIT stays in MWAIT while memstall, with WCNT←WCNT+1. If memstall holds while WCNT==TIMEOUT, the next state is HALT and ERR←1.
  - MWAIT→RUN when not memstall; WCNT←0.
  - HALT is left only by RESET.
- Counters:
  - STALL_CNT +1 on every cycle that applies a memstall or loaduse response.
  - FLUSH_CNT +1 on every cycle that applies a redirect response.
  - Both saturate at 2^CW−1 and do not wrap.

## Timing
- Reset values: state=RUN, WCNT=0, ERR=0, STALL_CNT=FLUSH_CNT=0.
- While RESET=1, all EN=1 and all FLUSH=1, so every pipeline register clears at the same edge. Counters do not count during reset.
- Hazard responses take effect in the same cycle the condition appears (zero latency). Counters, ERR and state update at the following edge.
- A memory wait of N cycles freezes PC through EX/MEM for exactly N cycles. The cycle with MEM_READY=1 is a normal cycle.
- The halt decision is made at the edge ending the (TIMEOUT+1)-th consecutive stalled cycle. ERR and HALT are visible from the next cycle onward. A MEM_READY that rises after that edge has no effect.
- Reset mid-wait or in HALT returns to RUN at the next edge and discards any stall in progress.

## Test plan
- **Reset:** hold RESET=1 for 2 cycles with random inputs → all EN=1, all FLUSH=1. After release, ERR=0, STALL_CNT=FLUSH_CNT=0, and with no hazards all EN=1 and all FLUSH=0.
- **Load-use:**
  - EX_MEMREAD=1, EX_RD=5, ID_RS2=5, ID_USE_RS2=1 → PC_EN=IFID_EN=0, IDEX_FLUSH=1, and STALL_CNT goes 0→1.
  - Same stimulus with EX_RD=0, or with ID_USE_RS2=0 → no stall.
- **Redirect with load-use:** apply both in the same cycle → PC_EN=1, IFID_FLUSH=IDEX_FLUSH=1, FLUSH_CNT +1, STALL_CNT unchanged.
- **Memory wait:** MEM_REQ=1 with MEM_READY=0 for 3 cycles, EX_BRANCH_TAKEN=1 throughout, then READY=1:
  - During the 3 wait cycles: PC–EXMEM enables=0 and MEMWB_FLUSH=1; STALL_CNT +3; no flush applied.
  - In the ready cycle the redirect is applied and FLUSH_CNT +1.
- **Timeout:** with TIMEOUT=4, hold MEM_READY=0 → ERR=1 after the 5th stall cycle and all EN=0. Raising MEM_READY has no effect; RESET clears ERR and returns to RUN.
- **Saturation:** with CW=4, apply load-use for 20 consecutive cycles → STALL_CNT=15 and stays at 15.

Source files
------------

// File: rtl/pipe_hazard_if.sv
// Hazard-controller bus: hazard sources from ID/EX/MEM in, register controls and perf counters out.
interface pipe_hazard_if #(
  parameter int unsigned RW = 5,
  parameter int unsigned CW = 32
);
  logic [RW-1:0] id_rs1;
  logic [RW-1:0] id_rs2;
  logic          id_use_rs1;
  logic          id_use_rs2;
  logic [RW-1:0] ex_rd;
  logic          ex_memread;
  logic          ex_branch_taken;
  logic          mem_req;
  logic          mem_ready;

  logic          pc_en;
  logic          ifid_en;
  logic          idex_en;
  logic          exmem_en;
  logic          memwb_en;
  logic          ifid_flush;
  logic          idex_flush;
  logic          exmem_flush;
  logic          memwb_flush;
  logic          err;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread, ex_branch_taken,
           mem_req, mem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush, err, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread, ex_branch_taken,
           mem_req, mem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush, err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, redirect and memory-wait handling,
// memory-timeout watchdog, and saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int unsigned RW      = 5,
  parameter int unsigned CW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input logic           CLK,
  input logic           RESET,
  pipe_hazard_if.slave  bus
);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StRun, StMwait, StHalt} state_e;

  state_e        state_q, state_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          err_q, err_d;
  logic [CW-1:0] stall_q, stall_d;
  logic [CW-1:0] flush_q, flush_d;

  logic       loaduse, memstall, redirect;
  logic       apply_stall, apply_flush;
  logic [4:0] en;  // {pc, ifid, idex, exmem, memwb}
  logic [3:0] fl;  // {ifid, idex, exmem, memwb}

  assign loaduse  = bus.ex_memread && (bus.ex_rd != RW'(0)) &&
                    ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                     (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));
  assign memstall = bus.mem_req && !bus.mem_ready;
  assign redirect = bus.ex_branch_taken;

  // Register controls, highest priority first.
  always_comb begin
    en          = 5'b11111;
    fl          = 4'b0000;
    apply_stall = 1'b0;
    apply_flush = 1'b0;
    if (RESET) begin
      fl = 4'b1111;
    end else if (state_q == StHalt) begin
      en = 5'b00000;
    end else if (memstall) begin
      en          = 5'b00001;
      fl          = 4'b0001;
      apply_stall = 1'b1;
    end else if (redirect) begin
      fl          = 4'b1100;
      apply_flush = 1'b1;
    end else if (loaduse) begin
      en          = 5'b00111;
      fl          = 4'b0100;
      apply_stall = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    unique case (state_q)
      StRun: begin
        if (memstall) begin
          state_d = StMwait;
          wcnt_d  = WW'(1);
        end
      end
      StMwait: begin
        if (!memstall) begin
          state_d = StRun;
          wcnt_d  = '0;
        end else if (wcnt_q == WW'(TIMEOUT)) begin
          state_d = StHalt;
          err_d   = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      default: state_d = StHalt;
    endcase
  end

  assign stall_d = (apply_stall && (stall_q != '1)) ? stall_q + CW'(1) : stall_q;
  assign flush_d = (apply_flush && (flush_q != '1)) ? flush_q + CW'(1) : flush_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StRun;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en} = en;
  assign {bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush} = fl;
  assign bus.err       = err_q;
  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
endmodule
